// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge pulse generator: per-channel synchroniser, debounce filter,
// selectable rise/fall/both edge detect, retriggerable pulse stretcher and sticky flag.
module multi_edge_pulse_gen #(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int PULSE_LEN   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_NUM-1:0]     signal_in,
    input  logic [2*CH_NUM-1:0]   edge_mode,
    input  logic [CH_NUM-1:0]     sticky_clr,
    output logic [CH_NUM-1:0]     pulse_out,
    output logic [CH_NUM-1:0]     level_out,
    output logic [CH_NUM-1:0]     edge_sticky
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);

    genvar gi;
    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic                   sync_s;
            logic                   filt_q;
            logic                   filt_d;
            logic                   filt_dly_q;
            logic [DW-1:0]          deb_cnt_q;
            logic [DW-1:0]          deb_cnt_d;
            logic [PW-1:0]          pcnt_q;
            logic [PW-1:0]          pcnt_d;
            logic                   pulse_q;
            logic                   sticky_q;
            logic                   sticky_d;
            logic                   rise;
            logic                   fall;
            logic                   hit;

            assign sync_s = sync_q[SYNC_STAGES-1];

            // Filtered level only moves after DEB_CYCLES consecutive disagreeing samples.
            always_comb begin
                filt_d    = filt_q;
                deb_cnt_d = deb_cnt_q;
                if (sync_s == filt_q) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    filt_d    = sync_s;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end

            assign rise = filt_q & ~filt_dly_q;
            assign fall = ~filt_q & filt_dly_q;
            // Mode is used live so a change in the edge cycle applies to that edge.
            assign hit  = (edge_mode[2*gi] & rise) | (edge_mode[2*gi+1] & fall);

            always_comb begin
                pcnt_d = pcnt_q;
                if (hit) begin
                    pcnt_d = PULSE_LOAD;
                end else if (pcnt_q != '0) begin
                    pcnt_d = pcnt_q - PW'(1);
                end
            end

            assign sticky_d = (sticky_q & ~sticky_clr[gi]) | hit;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q     <= '0;
                    filt_q     <= 1'b0;
                    filt_dly_q <= 1'b0;
                    deb_cnt_q  <= '0;
                    pcnt_q     <= '0;
                    pulse_q    <= 1'b0;
                    sticky_q   <= 1'b0;
                end else begin
                    sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_in[gi]};
                    filt_q     <= filt_d;
                    filt_dly_q <= filt_q;
                    deb_cnt_q  <= deb_cnt_d;
                    pcnt_q     <= pcnt_d;
                    pulse_q    <= (pcnt_d != '0);
                    sticky_q   <= sticky_d;
                end
            end

            assign pulse_out[gi]   = pulse_q;
            assign level_out[gi]   = filt_q;
            assign edge_sticky[gi] = sticky_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Bench for multi_edge_pulse_gen: directed scenarios with explicit edge timing
// plus randomized traffic against a window/timestamp reference model.
module tb_multi_edge_pulse_gen;
    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int PL   = 3;
    localparam int PL8  = 8;

    logic clk = 1'b0;
    logic rst;
    logic [CH-1:0]   signal_in;
    logic [CH-1:0]   sticky_clr;
    logic [2*CH-1:0] edge_mode;
    logic [CH-1:0]   pulse_out, level_out, edge_sticky;
    logic [CH-1:0]   pulse_out8, level_out8, edge_sticky8;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_edge_pulse_gen #(.CH_NUM(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .PULSE_LEN(PL)) u_dut (
        .clk(clk), .rst(rst), .signal_in(signal_in), .edge_mode(edge_mode), .sticky_clr(sticky_clr),
        .pulse_out(pulse_out), .level_out(level_out), .edge_sticky(edge_sticky)
    );

    multi_edge_pulse_gen #(.CH_NUM(CH), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .PULSE_LEN(PL8)) u_dut8 (
        .clk(clk), .rst(rst), .signal_in(signal_in), .edge_mode(edge_mode), .sticky_clr(sticky_clr),
        .pulse_out(pulse_out8), .level_out(level_out8), .edge_sticky(edge_sticky8)
    );

    // Reference model: raw input delay line, a window of synchronised samples that must all
    // disagree with the level to flip it, and the time of the last accepted edge per channel.
    bit [15:0] raw_win [CH];
    bit [63:0] s_win [CH];
    bit        m_f [CH];
    bit        m_fd [CH];
    longint    last_hit [CH] = '{default: -1000};
    longint    edge_no = 0;
    logic [CH-1:0] exp_level  = '0;
    logic [CH-1:0] exp_pulse  = '0;
    logic [CH-1:0] exp_pulse8 = '0;
    logic [CH-1:0] exp_sticky = '0;

    always @(posedge clk) begin
        bit s_old, f_old, fd_old, flip, hit;
        edge_no++;
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                raw_win[c]    = '0;
                s_win[c]      = '0;
                m_f[c]        = 1'b0;
                m_fd[c]       = 1'b0;
                last_hit[c]   = -1000;
                exp_sticky[c] = 1'b0;
            end else begin
                s_old  = raw_win[c][SYNC-1];
                f_old  = m_f[c];
                fd_old = m_fd[c];
                s_win[c] = {s_win[c][62:0], s_old};
                flip = 1'b1;
                for (int j = 0; j < DEB; j++) if (s_win[c][j] == f_old) flip = 1'b0;
                hit = (edge_mode[2*c] && f_old && !fd_old) || (edge_mode[2*c+1] && !f_old && fd_old);
                m_fd[c] = f_old;
                if (flip) m_f[c] = ~f_old;
                raw_win[c] = {raw_win[c][14:0], signal_in[c]};
                if (hit) last_hit[c] = edge_no;
                exp_sticky[c] = hit | (exp_sticky[c] & ~sticky_clr[c]);
            end
            exp_level[c]  = m_f[c];
            exp_pulse[c]  = (edge_no - last_hit[c]) < PL;
            exp_pulse8[c] = (edge_no - last_hit[c]) < PL8;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; signal_in = '0; edge_mode = '0; sticky_clr = '0;
        repeat (3) @(negedge clk);
        checks++; if (pulse_out !== '0) begin failures++; $display("FAIL reset_pulse got=%b exp=0000", pulse_out); end
        checks++; if (level_out !== '0) begin failures++; $display("FAIL reset_level got=%b exp=0000", level_out); end
        checks++; if (edge_sticky !== '0) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", edge_sticky); end
        checks++; if (pulse_out8 !== '0) begin failures++; $display("FAIL reset_pulse8 got=%b exp=0000", pulse_out8); end
        rst = 1'b0;
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_basic_rise();
        logic exp;
        edge_mode = 8'b0000_0001;
        idle(12);
        sticky_clr = '1; @(negedge clk); sticky_clr = '0;
        signal_in[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            exp = (e >= 6);
            checks++; if (level_out[0] !== exp) begin failures++; $display("FAIL rise_level edge=%0d got=%b exp=%b", e, level_out[0], exp); end
            exp = (e >= 7 && e <= 9);
            checks++; if (pulse_out[0] !== exp) begin failures++; $display("FAIL rise_pulse edge=%0d got=%b exp=%b", e, pulse_out[0], exp); end
            exp = (e >= 7);
            checks++; if (edge_sticky[0] !== exp) begin failures++; $display("FAIL rise_sticky edge=%0d got=%b exp=%b", e, edge_sticky[0], exp); end
            checks++; if ({pulse_out[3:1], level_out[3:1], edge_sticky[3:1]} !== 9'b0) begin
                failures++; $display("FAIL rise_others edge=%0d got=%b exp=0", e, {pulse_out[3:1], level_out[3:1], edge_sticky[3:1]});
            end
        end
        signal_in[0] = 1'b0;
        idle(15);
        $display("test_basic_rise done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_glitch();
        int highs, rises;
        logic prev;
        edge_mode = 8'b0000_1100;
        sticky_clr = '1; @(negedge clk); sticky_clr = '0;
        signal_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        signal_in[1] = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            checks++; if ({level_out[1], pulse_out[1], edge_sticky[1]} !== 3'b000) begin
                failures++; $display("FAIL glitch_quiet cycle=%0d got=%b exp=000", e, {level_out[1], pulse_out[1], edge_sticky[1]});
            end
        end
        highs = 0; rises = 0; prev = 1'b0;
        signal_in[1] = 1'b1;
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            if (e == 4) signal_in[1] = 1'b0;
            if (pulse_out[1]) highs++;
            if (pulse_out[1] && !prev) rises++;
            prev = pulse_out[1];
        end
        checks++; if (rises !== 2) begin failures++; $display("FAIL glitch4_pulses got=%0d exp=2", rises); end
        checks++; if (highs !== 2*PL) begin failures++; $display("FAIL glitch4_highs got=%0d exp=%0d", highs, 2*PL); end
        checks++; if (edge_sticky[1] !== 1'b1) begin failures++; $display("FAIL glitch4_sticky got=%b exp=1", edge_sticky[1]); end
        checks++; if (level_out[1] !== 1'b0) begin failures++; $display("FAIL glitch4_level got=%b exp=0", level_out[1]); end
        $display("test_glitch done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_mode_sweep();
        logic [1:0] modes [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        int exp_highs [4] = '{0, PL, PL, 0};
        int highs;
        for (int m = 0; m < 4; m++) begin
            edge_mode = '0;
            signal_in[2] = 1'b1;
            idle(10);
            sticky_clr[2] = 1'b1; @(negedge clk); sticky_clr[2] = 1'b0;
            edge_mode[5:4] = modes[m];
            signal_in[2] = 1'b0;
            highs = 0;
            for (int e = 0; e < 14; e++) begin
                @(negedge clk);
                if (pulse_out[2]) highs++;
            end
            checks++; if (highs !== exp_highs[m]) begin failures++; $display("FAIL sweep_highs mode=%b got=%0d exp=%0d", modes[m], highs, exp_highs[m]); end
            checks++; if (level_out[2] !== 1'b0) begin failures++; $display("FAIL sweep_level mode=%b got=%b exp=0", modes[m], level_out[2]); end
            checks++; if (edge_sticky[2] !== (exp_highs[m] > 0)) begin
                failures++; $display("FAIL sweep_sticky mode=%b got=%b exp=%b", modes[m], edge_sticky[2], exp_highs[m] > 0);
            end
        end
        $display("test_mode_sweep done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_retrigger();
        int highs8, rises8, highs3, rises3;
        logic prev8, prev3;
        edge_mode = '0;
        signal_in[3] = 1'b0;
        idle(12);
        edge_mode[7:6] = 2'b11;
        highs8 = 0; rises8 = 0; highs3 = 0; rises3 = 0; prev8 = 1'b0; prev3 = 1'b0;
        for (int e = 0; e < 45; e++) begin
            if (e % 6 == 0 && e / 6 < 5) signal_in[3] = ~signal_in[3];
            @(negedge clk);
            if (pulse_out8[3]) highs8++;
            if (pulse_out8[3] && !prev8) rises8++;
            if (pulse_out[3]) highs3++;
            if (pulse_out[3] && !prev3) rises3++;
            prev8 = pulse_out8[3];
            prev3 = pulse_out[3];
        end
        checks++; if (rises8 !== 1) begin failures++; $display("FAIL retrig_rises8 got=%0d exp=1", rises8); end
        checks++; if (highs8 !== 6*4 + PL8) begin failures++; $display("FAIL retrig_highs8 got=%0d exp=%0d", highs8, 6*4 + PL8); end
        checks++; if (rises3 !== 5) begin failures++; $display("FAIL retrig_rises3 got=%0d exp=5", rises3); end
        checks++; if (highs3 !== 5*PL) begin failures++; $display("FAIL retrig_highs3 got=%0d exp=%0d", highs3, 5*PL); end
        $display("test_retrigger done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_sticky();
        edge_mode = 8'b0000_0001;
        signal_in[0] = 1'b0;
        idle(10);
        signal_in[0] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            if (e == 7) begin
                checks++; if (edge_sticky[0] !== 1'b1) begin failures++; $display("FAIL sticky_set_wins got=%b exp=1", edge_sticky[0]); end
                checks++; if (pulse_out[0] !== 1'b1) begin failures++; $display("FAIL sticky_hit_pulse got=%b exp=1", pulse_out[0]); end
            end
            if (e == 8) begin
                checks++; if (edge_sticky[0] !== 1'b0) begin failures++; $display("FAIL sticky_clear got=%b exp=0", edge_sticky[0]); end
                sticky_clr[0] = 1'b0;
            end
            if (e == 6) sticky_clr[0] = 1'b1;
        end
        $display("test_sticky done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid();
        logic exp;
        edge_mode = 8'b0000_0001;
        signal_in[0] = 1'b0;
        idle(10);
        signal_in[0] = 1'b1;
        repeat (7) @(negedge clk);
        checks++; if (pulse_out[0] !== 1'b1) begin failures++; $display("FAIL midrst_pre_pulse got=%b exp=1", pulse_out[0]); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (pulse_out !== '0) begin failures++; $display("FAIL midrst_pulse got=%b exp=0000", pulse_out); end
        checks++; if (edge_sticky !== '0) begin failures++; $display("FAIL midrst_sticky got=%b exp=0000", edge_sticky); end
        checks++; if (level_out !== '0) begin failures++; $display("FAIL midrst_level got=%b exp=0000", level_out); end
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            exp = (e >= 6);
            checks++; if (level_out[0] !== exp) begin failures++; $display("FAIL midrst_relevel edge=%0d got=%b exp=%b", e, level_out[0], exp); end
            exp = (e >= 7 && e <= 9);
            checks++; if (pulse_out[0] !== exp) begin failures++; $display("FAIL midrst_repulse edge=%0d got=%b exp=%b", e, pulse_out[0], exp); end
        end
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            checks++; if (level_out !== exp_level) begin failures++; $display("FAIL rand_level cyc=%0d got=%b exp=%b", cyc, level_out, exp_level); end
            checks++; if (pulse_out !== exp_pulse) begin failures++; $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", cyc, pulse_out, exp_pulse); end
            checks++; if (edge_sticky !== exp_sticky) begin failures++; $display("FAIL rand_sticky cyc=%0d got=%b exp=%b", cyc, edge_sticky, exp_sticky); end
            checks++; if (pulse_out8 !== exp_pulse8) begin failures++; $display("FAIL rand_pulse8 cyc=%0d got=%b exp=%b", cyc, pulse_out8, exp_pulse8); end
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) signal_in[c] = ~signal_in[c];
                sticky_clr[c] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 19) == 0) edge_mode = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        $display("test_random done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        rst = 1'b1; signal_in = '0; edge_mode = '0; sticky_clr = '0;
        test_reset();
        test_basic_rise();
        test_glitch();
        test_mode_sweep();
        test_retrigger();
        test_sticky();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_edge_pulse_gen.md
Name: multi_edge_pulse_gen

Overview:
Parametrised, multi-channel successor to the single-channel rising-edge pulse generator. Each channel synchronises an asynchronous input, debounces it, detects a per-channel selectable edge type (rise, fall or both), and emits a retriggerable pulse of configurable length. A sticky per-channel event flag is also provided for register-mapped polling. Used for AD9516 status and lock lines, and for external trigger inputs, ahead of control FSMs.

Parameters:
CH_NUM, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flop stages per channel (>=2)
DEB_CYCLES, 4, consecutive cycles a synchronised level must differ from the filtered level before it is accepted (>=1)
PULSE_LEN, 3, pulse_out high time in clk cycles per accepted edge (>=1)

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  synchronous, active-high reset
signal_in  input  CH_NUM  asynchronous raw inputs, one bit per channel
edge_mode  input  2*CH_NUM  per-channel edge select; bits [2i+1:2i] belong to channel i; 00 = off, 01 = rise, 10 = fall, 11 = both
sticky_clr  input  CH_NUM  per-channel clear for edge_sticky
pulse_out  output  CH_NUM  stretched edge pulse
level_out  output  CH_NUM  debounced level (f)
edge_sticky  output  CH_NUM  latched "edge seen" flag

Behaviour:
- Reset (rst=1 at a clk edge): all synchroniser stages, f, f_d, the debounce counters, the pulse counters, pulse_out, level_out and edge_sticky go to 0. No output is X after the first reset edge.
- Sync: each channel has a SYNC_STAGES-deep flop chain. The last stage is s.
- Debounce, per channel, with counter width clog2(DEB_CYCLES+1):
  - If s==f: cnt<=0.
  - Else if cnt==DEB_CYCLES-1: f<=s and cnt<=0.
  - Else: cnt<=cnt+1.
  - level_out = f.
  - A mismatch shorter than DEB_CYCLES cycles does not change f and produces no pulse.
- Edge: f_d<=f every cycle. rise = f & ~f_d. fall = ~f & f_d.
  - hit = (mode[0] & rise) | (mode[1] & fall).
  - edge_mode is sampled live in the hit cycle. It is not registered.
- Pulse stretcher, per channel, with counter pcnt of width clog2(PULSE_LEN+1):
  - On hit: pcnt<=PULSE_LEN.
  - Else if pcnt!=0: pcnt<=pcnt-1.
  - pulse_out is registered and high iff the next pcnt is nonzero. pulse_out therefore rises on the edge after the hit cycle and stays high exactly PULSE_LEN cycles.
  - A hit while a pulse is active reloads pcnt to PULSE_LEN (retrigger). The pulse then extends with no low gap.
- Latency: count the first clk edge that samples a changed signal_in as edge 1.
  - level_out changes at edge SYNC_STAGES+DEB_CYCLES.
  - pulse_out rises at edge SYNC_STAGES+DEB_CYCLES+1.
  - With defaults these are edges 6 and 7.
- Sticky: edge_sticky<=(edge_sticky & ~sticky_clr) | hit. When set and clear coincide in the same cycle, set wins.
- Mode change:
  - A mode change does not truncate an active pulse.
  - Mode 00 blocks new hits; level_out still tracks the input.
  - Changing mode in a cycle where f_d!=f applies the new mode to that edge.
- Input high at reset release: f starts at 0, so a held-high input produces a rise (level_out=1 at edge SYNC+DEB after release), and a pulse if rise is enabled. This is intentional.
- Reset mid-operation: pulse_out and edge_sticky drop at the reset edge. No residual pulse appears after rst deasserts.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.

Test Plan:
1. Defaults, ch0 mode 01, rst released, signal_in[0] 0->1 held -> level_out[0]=1 at edge 6, pulse_out[0]=1 during edges 7..9 (3 cycles), edge_sticky[0]=1 from edge 7. Other channels stay 0.
2. Glitch: signal_in[1] high for 3 cycles, mode 11 -> level_out[1], pulse_out[1] and edge_sticky[1] stay 0. Repeat with a 4-cycle high -> one rise pulse, then one fall pulse.
3. Mode sweep on ch2 with a 1->0 transition: mode 01 -> no pulse; 10 -> 3-cycle pulse; 11 -> pulse; 00 -> no pulse but level_out[2] falls.
4. Retrigger: ch3 mode 11, PULSE_LEN=8 build, input toggled every 6 cycles after settling -> pulse_out[3] stays continuously high until 8 cycles after the last accepted edge.
5. Sticky: hit and sticky_clr[0] in the same cycle -> edge_sticky[0] stays 1. sticky_clr[0] alone next cycle -> 0 on the following edge.
6. Reset: assert rst during cycle 2 of a pulse -> pulse_out=0 on that edge. Deassert with signal_in[0] held 1 -> fresh pulse at edge 7 after release.
